// File: rtl/axil_sram_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// FSM state encoding and bus word types.
package axil_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  typedef logic [31:0] ysyx_23060251_axi_addr_bus;
  typedef logic [31:0] ysyx_23060251_axi_data_bus;

endpackage

// File: rtl/axil_sram_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5.
// Used only when YSYX_23060251_SRAM_RAND_DELAY_EN is defined.
module ysyx_23060251_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_q <= 8'hA5;
    end else if (en_i) begin
      q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite SRAM responder, one transaction in flight, programmable response delay.
// Define YSYX_23060251_SRAM_RAND_DELAY_EN to replace LAT with an LFSR-driven 0..7 delay.
module axil_sram
  import axil_sram_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
  parameter int                LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   SPAN  = (ADDR_W+1)'(DEPTH) << 2;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d, dly;
  logic              live_q;
  logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        rresp_q, rresp_d, bresp_q, bresp_d;
  logic              mem_we;
  logic [ADDR_W-1:0] r_off, w_off;
  logic              r_ok, w_ok;

`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  ysyx_23060251_lfsr8 u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .q_o   (lfsr)
  );
  assign dly = {1'b0, lfsr[2:0]};
`else
  assign dly = 4'(LAT);
`endif

  // Offsets wrap below BASE, so the lower bound is checked on the raw address.
  assign r_off = raddr_q - BASE;
  assign w_off = waddr_q - BASE;
  assign r_ok  = (raddr_q >= BASE) && ({1'b0, r_off} < SPAN);
  assign w_ok  = (waddr_q >= BASE) && ({1'b0, w_off} < SPAN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    arready_o = 1'b0;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    rvalid_o  = 1'b0;
    bvalid_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (live_q) begin
          arready_o = 1'b1;
          awready_o = !aw_held_q && !arvalid_i;
          wready_o  = !w_held_q && !arvalid_i;
          if (arvalid_i) begin
            raddr_d = araddr_i;
            cnt_d   = dly;
            state_d = ST_RD_WAIT;
          end else begin
            if (awvalid_i && awready_o) begin
              aw_held_d = 1'b1;
              waddr_d   = awaddr_i;
            end
            if (wvalid_i && wready_o) begin
              w_held_d = 1'b1;
              wdata_d  = wdata_i;
              wstrb_d  = wstrb_i;
            end
            if (aw_held_d && w_held_d) begin
              cnt_d   = dly;
              state_d = ST_WR_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RD_RESP;
          rdata_d = r_ok ? mem[r_off[IDX_W+1:2]] : '0;
          rresp_d = r_ok ? RESP_OKAY : RESP_DECERR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) state_d = ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_WR_RESP;
          mem_we  = w_ok;
          bresp_d = w_ok ? RESP_OKAY : RESP_DECERR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) begin
          state_d   = ST_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      live_q    <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      live_q    <= 1'b1;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-lane write happens on the edge that enters WR_RESP.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[w_off[IDX_W+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign rresp_o = rresp_q;
  assign bresp_o = bresp_q;

endmodule

// File: doc/axil_sram.md
# axil_sram

AXI4-Lite memory responder (slave) that serves the core's fetch and load/store initiators. It holds a word-addressed SRAM array and answers one transaction at a time through a single FSM. Response latency is programmable, so the initiator handshakes can be stressed before real memory is attached. It sits between the core's bus masters (or an arbiter) and simulated memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; only 32 is supported
- DEPTH, 4096, number of 32-bit words; power of two
- BASE, 32'h8000_0000, byte address of word 0
- LAT, 1, idle cycles between request acceptance and response valid (0..15)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- araddr_i  in  ADDR_W  read address
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- rdata_o  out  32  read data
- rresp_o  out  2  read response
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- awaddr_i  in  ADDR_W  write address
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- wdata_i  in  32  write data
- wstrb_i  in  4  byte strobes
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- bresp_o  out  2  write response
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE, read path:
  - arready_o = 1.
  - On an AR handshake: latch the address, load the delay counter, and go to RD_WAIT.
- IDLE, write path:
  - awready_o = !aw_held && !arvalid_i; wready_o = !w_held && !arvalid_i.
  - AW and W are captured independently, in either order, possibly in different cycles.
  - Once both are held, go to WR_WAIT.
- Simultaneous arvalid_i and awvalid_i/wvalid_i in IDLE: read wins. AW/W stay unaccepted until the FSM returns to IDLE.
- RD_WAIT / WR_WAIT: the counter decrements each cycle. At 0, go to RD_RESP / WR_RESP.
- Address decode:
  - index = (addr - BASE) >> 2.
  - The address is in range if BASE <= addr < BASE + 4*DEPTH.
  - addr[1:0] is ignored.
- RD_RESP:
  - rvalid_o = 1.
  - rdata_o = mem[index] and rresp_o = OKAY (2'b00) if in range; otherwise rdata_o = 0 and rresp_o = DECERR (2'b11).
  - rdata_o and rresp_o stay stable while rvalid_o && !rready_i.
  - Return to IDLE on the R handshake.
- WR_RESP:
  - On entry, if in range, write each byte lane whose wstrb_i bit was set (one write per transaction). Out-of-range writes change nothing and respond DECERR.
  - bvalid_o = 1 and is held until the B handshake, then return to IDLE; aw_held and w_held clear.
- Every transaction gets exactly one response. There is no outstanding-transaction queue.

## Timing
- Reset values: all ready and valid outputs 0; rdata_o = 0; rresp_o = 0; bresp_o = 0; FSM in IDLE; aw_held = w_held = 0; memory contents are not reset.
- arready_o first rises in the first clk_i edge after rst_i deasserts.
- Read latency: rvalid_o rises LAT+1 cycles after the AR handshake edge. With LAT=0, rvalid_o is high in the very next cycle.
- Write latency: bvalid_o rises LAT+1 cycles after the cycle in which both AW and W are held. The memory update is visible to a read accepted after the B handshake.
- Read-after-write with no B handshake yet is impossible, because a single transaction is in flight.
- Reset mid-transaction: the in-flight transaction is dropped with no response. A write that has not reached WR_RESP does not modify memory.

## Configuration
- YSYX_23060251_SRAM_RAND_DELAY_EN defined:
  - LAT is ignored.
  - Each accepted request loads the counter from a free-running 8-bit LFSR: delay = lfsr[2:0], giving 0..7 wait cycles.
  - The LFSR seeds to 8'hA5 at reset and advances every cycle (taps 8,6,5,4).
- Not defined: fixed LAT delay; no LFSR logic is instantiated.

## Structure
- The `defines` header gets the response codes (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11), the FSM state encodings, and ysyx_23060251_axi_addr_bus / ysyx_23060251_axi_data_bus.
- One sub-module: ysyx_23060251_lfsr8 (clk_i, rst_i, en_i, q_o[7:0]), instantiated only under the macro.
- The memory array is an inline reg array inside axil_sram.

## Test plan
- Preload mem[0] = 32'hDEAD_BEEF, LAT=2, read 32'h8000_0000 with rready_i high → rvalid_o rises in the 3rd cycle after the AR handshake; rdata_o = 32'hDEAD_BEEF, rresp_o = 2'b00.
- Write 32'h1234_5678 with wstrb_i = 4'b0101 to 32'h8000_0004 over old value 32'hFFFF_FFFF, then read the same address → bresp_o = 2'b00, read returns 32'hFF34_FF78.
- Present W two cycles before AW → both are captured, a single B response is returned, and memory is updated once.
- Assert arvalid_i and awvalid_i/wvalid_i in the same IDLE cycle → the read completes first; awready_o = 0 until after the R handshake, then the write completes.
- Read 32'h7FFF_FFFC and write 32'h8000_4000 (DEPTH=4096) → rresp_o = 2'b11 with rdata_o = 0; bresp_o = 2'b11; memory is unchanged.
- Hold rready_i low for 5 cycles during RD_RESP, then pulse rst_i low during WR_WAIT → rdata_o/rvalid_o stay stable while stalled; after reset all valids are 0 and the target word is unchanged.
